// File: rtl/traffic_phase_controller_pkg.sv
// Shared definitions for the intersection phase controller:
// phase codes, light encodings and the seconds-display saturation helper.
package traffic_defs;

    typedef enum logic [2:0] {
        PH_ALL_RED_B  = 3'd0,
        PH_ROW_GREEN  = 3'd1,
        PH_ROW_YELLOW = 3'd2,
        PH_ALL_RED_A  = 3'd3,
        PH_COL_GREEN  = 3'd4,
        PH_COL_YELLOW = 3'd5,
        PH_FLASH_ON   = 3'd6,
        PH_FLASH_OFF  = 3'd7
    } phase_e;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;

    // Two-digit display limit.
    function automatic logic [6:0] sat99(input logic [7:0] v);
        return (v > 8'd99) ? 7'd99 : v[6:0];
    endfunction

endpackage

// File: rtl/traffic_phase_controller_tick.sv
// One-second tick generator: counts 0..CLOCK_DIV-1, tick high on the last count.
// Ports: clock, reset (async, active-high) in; tick out (one clock wide).
module tick_generator #(
    parameter int CLOCK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int W = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLOCK_DIV - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        tick    = (count_q == LAST);
        count_d = tick ? '0 : count_q + W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-road intersection phase sequencer with green truncation on cross-road requests
// and night flashing. Ports: clock, reset, row/column_request, night_mode in;
// row/column_traffic_lights {r,y,g}, row/column_remaining (s), phase code out.
module traffic_phase_controller
    import traffic_defs::*;
#(
    parameter int CLOCK_DIV    = 50_000_000,
    parameter int GREEN_TIME   = 28,
    parameter int YELLOW_TIME  = 4,
    parameter int ALL_RED_TIME = 1,
    parameter int MIN_GREEN    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       row_request,
    input  logic       column_request,
    input  logic       night_mode,
    output logic [2:0] row_traffic_lights,
    output logic [2:0] column_traffic_lights,
    output logic [6:0] row_remaining,
    output logic [6:0] column_remaining,
    output logic [2:0] phase
);

    localparam logic [5:0] G6 = 6'(GREEN_TIME);
    localparam logic [5:0] Y6 = 6'(YELLOW_TIME);
    localparam logic [5:0] R6 = 6'(ALL_RED_TIME);
    localparam logic [5:0] M6 = 6'(MIN_GREEN);
    localparam logic [7:0] G8 = 8'(GREEN_TIME);
    localparam logic [7:0] Y8 = 8'(YELLOW_TIME);
    localparam logic [7:0] R8 = 8'(ALL_RED_TIME);
    localparam logic [6:0] RST_COL_REM = sat99(R8 + G8 + Y8 + R8);

    function automatic logic [5:0] phase_time(input phase_e p);
        case (p)
            PH_ROW_GREEN, PH_COL_GREEN:   return G6;
            PH_ROW_YELLOW, PH_COL_YELLOW: return Y6;
            PH_ALL_RED_A, PH_ALL_RED_B:   return R6;
            default:                      return 6'd0;
        endcase
    endfunction

    logic       tick;
    logic       expire;
    logic       trunc;
    logic [7:0] t8;
    logic [7:0] row_sum;
    logic [7:0] col_sum;

    phase_e     state_q, state_d;
    logic [5:0] timer_q, timer_d;
    logic       req_row_q, req_row_d;
    logic       req_col_q, req_col_d;
    logic [2:0] row_lights_q, row_lights_d;
    logic [2:0] col_lights_q, col_lights_d;
    logic [6:0] row_rem_q, row_rem_d;
    logic [6:0] col_rem_q, col_rem_d;

    tick_generator #(.CLOCK_DIV(CLOCK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        req_row_d = req_row_q | row_request;
        req_col_d = req_col_q | column_request;
        expire    = tick && (timer_q == 6'd1);
        trunc     = 1'b0;

        unique case (state_q)
            PH_ALL_RED_B:
                if (expire) state_d = night_mode ? PH_FLASH_ON : PH_ROW_GREEN;
            PH_ROW_GREEN:
                if (expire) state_d = PH_ROW_YELLOW;
                else        trunc   = req_col_d && (timer_q > M6);
            PH_ROW_YELLOW:
                if (expire) state_d = PH_ALL_RED_A;
            PH_ALL_RED_A:
                if (expire) state_d = night_mode ? PH_FLASH_ON : PH_COL_GREEN;
            PH_COL_GREEN:
                if (expire) state_d = PH_COL_YELLOW;
                else        trunc   = req_row_d && (timer_q > M6);
            PH_COL_YELLOW:
                if (expire) state_d = PH_ALL_RED_B;
            PH_FLASH_ON:
                if (tick) state_d = night_mode ? PH_FLASH_OFF : PH_ALL_RED_B;
            PH_FLASH_OFF:
                if (tick) state_d = night_mode ? PH_FLASH_ON : PH_ALL_RED_B;
        endcase

        // A phase change always reloads; truncation beats the plain decrement.
        if (state_d != state_q) timer_d = phase_time(state_d);
        else if (trunc)         timer_d = M6;
        else if (tick)          timer_d = timer_q - 6'd1;

        if (state_d == PH_ROW_GREEN && state_q != PH_ROW_GREEN) req_row_d = 1'b0;
        if (state_d == PH_COL_GREEN && state_q != PH_COL_GREEN) req_col_d = 1'b0;
        if (state_q inside {PH_FLASH_ON, PH_FLASH_OFF} ||
            state_d inside {PH_FLASH_ON, PH_FLASH_OFF}) begin
            req_row_d = 1'b0;
            req_col_d = 1'b0;
        end

        // Outputs are computed from the next state so they register with it.
        t8           = {2'b00, timer_d};
        row_sum      = 8'd0;
        col_sum      = 8'd0;
        row_lights_d = LIGHT_RED;
        col_lights_d = LIGHT_RED;
        unique case (state_d)
            PH_ALL_RED_B: begin
                row_sum = t8;
                col_sum = t8 + G8 + Y8 + R8;
            end
            PH_ROW_GREEN: begin
                row_lights_d = LIGHT_GREEN;
                row_sum      = t8;
                col_sum      = t8 + Y8 + R8;
            end
            PH_ROW_YELLOW: begin
                row_lights_d = LIGHT_YELLOW;
                row_sum      = t8;
                col_sum      = t8 + R8;
            end
            PH_ALL_RED_A: begin
                row_sum = t8 + G8 + Y8 + R8;
                col_sum = t8;
            end
            PH_COL_GREEN: begin
                col_lights_d = LIGHT_GREEN;
                col_sum      = t8;
                row_sum      = t8 + Y8 + R8;
            end
            PH_COL_YELLOW: begin
                col_lights_d = LIGHT_YELLOW;
                col_sum      = t8;
                row_sum      = t8 + R8;
            end
            PH_FLASH_ON: begin
                row_lights_d = LIGHT_YELLOW;
                col_lights_d = LIGHT_YELLOW;
            end
            PH_FLASH_OFF: begin
                row_lights_d = LIGHT_OFF;
                col_lights_d = LIGHT_OFF;
            end
        endcase
        row_rem_d = sat99(row_sum);
        col_rem_d = sat99(col_sum);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= PH_ALL_RED_B;
            timer_q      <= R6;
            req_row_q    <= 1'b0;
            req_col_q    <= 1'b0;
            row_lights_q <= LIGHT_RED;
            col_lights_q <= LIGHT_RED;
            row_rem_q    <= sat99(R8);
            col_rem_q    <= RST_COL_REM;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            req_row_q    <= req_row_d;
            req_col_q    <= req_col_d;
            row_lights_q <= row_lights_d;
            col_lights_q <= col_lights_d;
            row_rem_q    <= row_rem_d;
            col_rem_q    <= col_rem_d;
        end
    end

    assign row_traffic_lights    = row_lights_q;
    assign column_traffic_lights = col_lights_q;
    assign row_remaining         = row_rem_q;
    assign column_remaining      = col_rem_q;
    assign phase                 = state_q;

endmodule
